lm32_dp_ram: RTL and testbench

- Simple dual-port RAM: one write port, one read port, single clock.
- Used as the storage array for lm32 TLBs and caches, e.g. the DTLB stores {valid, tag, pfn} per set.
- Read port registers the read address; read data is the combinational array output at the registered address.
- Depth is 2^address_width words of data_width bits.

---
 rtl/lm32_dp_ram.sv | 81 ++++++++
 tb/tb_lm32_dp_ram.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lm32_dp_ram.sv
// Simple dual-port RAM (one write port, one registered-address read port, single clock).
// Define LM32_RAM_CLEAR_EN to zero the array with a sweep after every reset.
module lm32_dp_ram #(
    parameter int data_width    = 32,
    parameter int address_width = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [address_width-1:0] read_address,
    input  logic                     enable_read,
    input  logic [address_width-1:0] write_address,
    input  logic                     enable_write,
    input  logic                     write_enable,
    input  logic [data_width-1:0]    write_data,
    output logic [data_width-1:0]    read_data,
    output logic                     busy
);

    localparam int unsigned DEPTH = 2 ** address_width;

    logic [data_width-1:0]    r_mem [0:DEPTH-1];
    logic [address_width-1:0] r_ra;

    logic                     w_we;
    logic [address_width-1:0] w_wa;
    logic [data_width-1:0]    w_wd;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ra <= '0;
        end else if (enable_read) begin
            r_ra <= read_address;
        end
    end

`ifdef LM32_RAM_CLEAR_EN
    localparam logic [address_width-1:0] CC_STEP = 1;

    logic [address_width-1:0] r_cc;
    logic                     r_busy;

    // Sweep runs from the top address down; busy drops once address 0 is written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cc   <= '1;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_cc <= r_cc - CC_STEP;
            if (r_cc == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        w_we = r_busy | (enable_write & write_enable);
        w_wa = r_busy ? r_cc : write_address;
        w_wd = r_busy ? '0 : write_data;
    end

    assign busy      = r_busy;
    assign read_data = r_busy ? '0 : r_mem[r_ra];
`else
    always_comb begin
        w_we = enable_write & write_enable;
        w_wa = write_address;
        w_wd = write_data;
    end

    assign busy      = 1'b0;
    assign read_data = r_mem[r_ra];
`endif

    // No reset on the array so it maps to block RAM; writes under reset are dropped.
    always_ff @(posedge clk_i) begin
        if (w_we && !rst_i) begin
            r_mem[w_wa] <= w_wd;
        end
    end

endmodule

// File: tb/tb_lm32_dp_ram.sv
// Self-checking bench for lm32_dp_ram: directed steps then random traffic against an array model.
// Also covers the LM32_RAM_CLEAR_EN sweep when that macro is defined.
module tb_lm32_dp_ram;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 2 ** AW;
`ifdef LM32_RAM_CLEAR_EN
    localparam int CLEAR_CYCLES = DEPTH;
`else
    localparam int CLEAR_CYCLES = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] read_address  = '0;
    logic          enable_read   = 1'b0;
    logic [AW-1:0] write_address = '0;
    logic          enable_write  = 1'b0;
    logic          write_enable  = 1'b0;
    logic [DW-1:0] write_data    = '0;
    logic [DW-1:0] read_data;
    logic          busy;

    lm32_dp_ram #(.data_width(DW), .address_width(AW)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .read_address(read_address),
        .enable_read(enable_read),
        .write_address(write_address),
        .enable_write(enable_write),
        .write_enable(write_enable),
        .write_data(write_data),
        .read_data(read_data),
        .busy(busy)
    );

    always #5 clk_i = ~clk_i;

    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_valid [DEPTH];
    int            m_ra;
    int            sweep_left;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [DW-1:0] exp_busy;
        exp_busy = (sweep_left > 0) ? 1 : 0;
        check_val({tag, "_busy"}, {{(DW-1){1'b0}}, busy}, exp_busy);
        if (sweep_left > 0) begin
            check_val({tag, "_rd_busy"}, read_data, '0);
        end else if (m_valid[m_ra]) begin
            check_val({tag, "_rd"}, read_data, m_mem[m_ra]);
        end
    endtask

    // One clock: the model applies this edge's write before the read capture (write-first).
    task automatic step(input string tag);
        @(posedge clk_i);
        if (!rst_i) begin
            if (sweep_left > 0) begin
                sweep_left--;
                if (sweep_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        m_mem[i]   = '0;
                        m_valid[i] = 1'b1;
                    end
                end
            end else if (enable_write && write_enable) begin
                m_mem[write_address]   = write_data;
                m_valid[write_address] = 1'b1;
            end
            if (enable_read) m_ra = int'(read_address);
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        enable_read  = 1'b0;
        enable_write = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        enable_write = 1'b1; write_enable = 1'b1; write_address = a; write_data = d;
        step("wr");
        idle_inputs();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        enable_read = 1'b1; read_address = a;
        step("rd");
        idle_inputs();
    endtask

    // Covers the clear sweep (if built in) with write attempts that must be ignored.
    task automatic post_reset_traffic();
        for (int i = 0; i <= CLEAR_CYCLES; i++) begin
            enable_write  = 1'b1;
            write_enable  = 1'b1;
            write_address = AW'($urandom_range(DEPTH - 1));
            write_data    = $urandom;
            enable_read   = 1'b1;
            read_address  = AW'($urandom_range(DEPTH - 1));
            step("sweep");
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_valid[i] = 1'b0;
        end
        m_ra       = 0;
        sweep_left = CLEAR_CYCLES;

        #1;
        check_outputs("reset");
        step("reset_hold");
        step("reset_hold");
        rst_i = 1'b0;
        check_outputs("release");
        post_reset_traffic();

        wr(0, 32'h0000_0000);
        wr(5, 32'hDEAD_BEEF);
        rd(5);
        check_val("rd5", read_data, 32'hDEAD_BEEF);

        wr(7, 32'h1234_5678);
        enable_write = 1'b0; write_enable = 1'b1; write_address = 7; write_data = 32'hFFFF_FFFF;
        step("gate_ew");
        enable_write = 1'b1; write_enable = 1'b0; write_data = 32'hCAFE_F00D;
        step("gate_we");
        idle_inputs();
        rd(7);
        check_val("gated", read_data, 32'h1234_5678);

        wr(3, 32'h0000_00A5);
        rd(3);
        check_val("rd3", read_data, 32'h0000_00A5);
        read_address = 4;
        step("hold");
        check_val("hold", read_data, 32'h0000_00A5);
        wr(3, 32'h0000_005A);
        check_val("hold_wr", read_data, 32'h0000_005A);

        enable_read = 1'b1; read_address = 9;
        enable_write = 1'b1; write_enable = 1'b1; write_address = 9; write_data = 32'h0F0F_0F0F;
        step("same_edge");
        idle_inputs();
        check_val("same_edge", read_data, 32'h0F0F_0F0F);

        for (int i = 0; i < 300; i++) begin
            enable_read   = ($urandom_range(3) != 0);
            read_address  = AW'($urandom_range(DEPTH - 1));
            enable_write  = ($urandom_range(3) != 0);
            write_enable  = ($urandom_range(3) != 0);
            write_address = AW'($urandom_range(DEPTH - 1));
            write_data    = $urandom;
            step("rand");
        end
        idle_inputs();

        rd(9);
        #2;
        rst_i = 1'b1;
        m_ra       = 0;
        sweep_left = CLEAR_CYCLES;
        #1;
        check_outputs("async_rst");
        enable_write = 1'b1; write_enable = 1'b1; write_address = 0; write_data = 32'hBAD0_BAD0;
        step("wr_in_rst");
        idle_inputs();
        rst_i = 1'b0;
        post_reset_traffic();

        for (int a = 0; a < DEPTH; a++) begin
            rd(AW'(a));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
